// File: rtl/mnist_pkg.sv
// Shared constants, state types and label encoding for the MNIST frame packer.
// The 794-bit frame carries 784 binarised pixels above a 10-bit one-hot label.
package mnist_pkg;

  localparam int NPIX    = 784;
  localparam int LABEL_W = 10;
  localparam int IMG_W   = 794;
  localparam int PIX_LSB = 10;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } out_state_e;

  // Digits above 9 have no class and encode as all zeros.
  function automatic logic [LABEL_W-1:0] label_onehot(input logic [3:0] digit);
    logic [LABEL_W-1:0] oh;
    if (digit <= 4'd9) begin
      oh = 10'd1 << digit;
    end else begin
      oh = 10'd0;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mnist_binarize_beat.sv
// Thresholds every byte of one input beat into a single pixel bit.
module mnist_binarize_beat #(
  parameter int BEAT_PIX = 8,
  parameter int BIN_THR  = 128
) (
  input  logic [8*BEAT_PIX-1:0] pix_data,
  output logic [BEAT_PIX-1:0]   pix_bits
);

  // One comparator per byte lane.
  always_comb begin
    pix_bits = '0;
    for (int k = 0; k < BEAT_PIX; k++) begin
      pix_bits[k] = (pix_data[8*k +: 8] >= 8'(BIN_THR));
    end
  end

endmodule

// File: rtl/mnist_frame_packer.sv
// Assembles binarised pixel beats into 794-bit frames and presents each frame
// to the class learners for a programmable hold time, double-buffered.
module mnist_frame_packer
  import mnist_pkg::*;
#(
  parameter int BEAT_PIX = 8,
  parameter int BIN_THR  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [8*BEAT_PIX-1:0] s_data,
  input  logic                  s_last,
  input  logic [3:0]            s_label,
  input  logic [15:0]           hold_cycles,
  output logic [IMG_W-1:0]      image_data,
  output logic                  img_valid,
  output logic                  frame_done,
  output logic                  err,
  output logic [15:0]           frame_cnt
);

  localparam int NBEATS = NPIX / BEAT_PIX;
  localparam int BCW    = $clog2(NBEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

  fill_state_e          fill_q, fill_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic [NPIX-1:0]      buf_q, buf_d;
  logic [LABEL_W-1:0]   lbl_q, lbl_d;
  logic                 swallow_q, swallow_d;
  logic                 err_q, err_d;
  logic                 s_ready_q, s_ready_d;

  out_state_e           out_q, out_d;
  logic [15:0]          hold_q, hold_d;
  logic [IMG_W-1:0]     img_q, img_d;
  logic                 img_valid_q, img_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  logic [BEAT_PIX-1:0]  beat_bits;
  logic                 accept;
  logic                 last_hold;
  logic                 transfer;

  mnist_binarize_beat #(
    .BEAT_PIX (BEAT_PIX),
    .BIN_THR  (BIN_THR)
  ) u_binarize (
    .pix_data (s_data),
    .pix_bits (beat_bits)
  );

  assign accept    = s_valid && s_ready_q;
  assign last_hold = (out_q == SHOW) && (hold_q == 16'd1);
  assign transfer  = (fill_q == FULL) && ((out_q == IDLE) || last_hold);

  // Fill FSM: beat placement, label capture and malformed-frame dropping.
  always_comb begin
    fill_d    = fill_q;
    beat_d    = beat_q;
    buf_d     = buf_q;
    lbl_d     = lbl_q;
    swallow_d = swallow_q;
    err_d     = 1'b0;
    if (transfer) begin
      fill_d = FILL;
    end else if (accept) begin
      if (swallow_q) begin
        // Bad-label frame: discard beats until its s_last.
        swallow_d = ~s_last;
        beat_d    = '0;
      end else if ((beat_q == '0) && (s_label > 4'd9)) begin
        err_d     = 1'b1;
        swallow_d = ~s_last;
        beat_d    = '0;
      end else if (s_last != (beat_q == LAST_BEAT)) begin
        err_d  = 1'b1;
        beat_d = '0;
      end else begin
        buf_d[int'(beat_q)*BEAT_PIX +: BEAT_PIX] = beat_bits;
        if (beat_q == '0) begin
          lbl_d = label_onehot(s_label);
        end else begin
          lbl_d = lbl_q;
        end
        if (s_last) begin
          fill_d = FULL;
          beat_d = '0;
        end else begin
          beat_d = beat_q + BCW'(1);
        end
      end
    end else begin
      fill_d = fill_q;
    end
    s_ready_d = (fill_d == FILL);
  end

  // Output FSM: load on transfer, count down the hold, blank when idle.
  always_comb begin
    out_d       = out_q;
    hold_d      = hold_q;
    img_d       = img_q;
    img_valid_d = img_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (transfer) begin
      out_d       = SHOW;
      img_d       = {buf_q, lbl_q};
      img_valid_d = 1'b1;
      hold_d      = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (last_hold) begin
      out_d       = IDLE;
      img_d       = '0;
      img_valid_d = 1'b0;
      hold_d      = 16'd0;
    end else if (out_q == SHOW) begin
      hold_d = hold_q - 16'd1;
    end else begin
      hold_d = hold_q;
    end
    frame_done_d = (out_d == SHOW) && (hold_d == 16'd1);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q       <= FILL;
      beat_q       <= '0;
      buf_q        <= '0;
      lbl_q        <= '0;
      swallow_q    <= 1'b0;
      err_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      out_q        <= IDLE;
      hold_q       <= 16'd0;
      img_q        <= '0;
      img_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      fill_q       <= fill_d;
      beat_q       <= beat_d;
      buf_q        <= buf_d;
      lbl_q        <= lbl_d;
      swallow_q    <= swallow_d;
      err_q        <= err_d;
      s_ready_q    <= s_ready_d;
      out_q        <= out_d;
      hold_q       <= hold_d;
      img_q        <= img_d;
      img_valid_q  <= img_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign image_data = img_q;
  assign img_valid  = img_valid_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_mnist_frame_packer.sv
// Scoreboard bench for mnist_frame_packer: expected frames are queued when a
// well-formed frame is driven and checked when frame_cnt advances.
module tb_mnist_frame_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         s_last;
  logic [3:0]   s_label;
  logic [15:0]  hold_cycles;
  logic [793:0] image_data;
  logic         img_valid;
  logic         frame_done;
  logic         err;
  logic [15:0]  frame_cnt;

  mnist_frame_packer dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_label     (s_label),
    .hold_cycles (hold_cycles),
    .image_data  (image_data),
    .img_valid   (img_valid),
    .frame_done  (frame_done),
    .err         (err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [793:0] img;
    int           hold;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           tests_run = 0;
  int           failed = 0;
  logic [7:0]   pix_mem [0:783];
  int           err_cnt = 0;
  int           done_cnt = 0;
  int           gap_cnt = 0;
  bit           gap_en = 1'b0;
  int           exp_frames = 0;
  logic [15:0]  prev_cnt = 16'd0;
  logic [793:0] cur_img;
  int           cur_len = 0;
  int           cur_hold = 0;
  bit           cur_act = 1'b0;

  // Output monitor: frame contents at load, stability and hold length.
  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = 16'd0;
      cur_act  = 1'b0;
    end else begin
      if (err === 1'b1) err_cnt++;
      if (gap_en && img_valid !== 1'b1) gap_cnt++;
      if (frame_cnt !== prev_cnt) begin
        prev_cnt = frame_cnt;
        tests_run++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL load_unexpected: frame_cnt=%0d but no frame expected", frame_cnt);
          cur_act = 1'b0;
        end else begin
          mon_e = sb.pop_front();
          if (image_data !== mon_e.img) begin
            failed++;
            $display("FAIL load_image: got %h exp %h", image_data, mon_e.img);
          end
          cur_img  = mon_e.img;
          cur_hold = mon_e.hold;
          cur_len  = 1;
          cur_act  = 1'b1;
        end
      end else if (cur_act && img_valid === 1'b1) begin
        cur_len++;
        tests_run++;
        if (image_data !== cur_img) begin
          failed++;
          $display("FAIL image_stable: image_data changed during hold (label bits %h exp %h)",
                   image_data[9:0], cur_img[9:0]);
        end
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        tests_run++;
        if (!cur_act || cur_len != cur_hold) begin
          failed++;
          $display("FAIL hold_length: got %0d cycles exp %0d (active=%0d)", cur_len, cur_hold, cur_act);
        end
        cur_act = 1'b0;
      end
    end
  end

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 784; i++) pix_mem[i] = v;
  endtask

  task automatic fill_alt();
    for (int i = 0; i < 784; i++) pix_mem[i] = (i % 2 == 1) ? 8'd128 : 8'd127;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 784; i++) pix_mem[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input logic [3:0] label, input int hold);
    exp_t e;
    e.img = '0;
    for (int i = 0; i < 784; i++) e.img[10+i] = (pix_mem[i] >= 8'd128);
    e.img[label] = 1'b1;
    e.hold = (hold == 0) ? 1 : hold;
    sb.push_back(e);
    exp_frames++;
  endtask

  // Drives nbeats beats, asserting s_last on beat last_at (-1: never).
  task automatic send_frame(input logic [3:0] label, input int last_at, input int nbeats,
                            output int accepted);
    int w;
    accepted = 0;
    for (int b = 0; b < nbeats; b++) begin
      s_valid = 1'b1;
      s_label = label;
      s_last  = (b == last_at);
      for (int k = 0; k < 8; k++) s_data[8*k +: 8] = pix_mem[b*8+k];
      w = 0;
      while (s_ready !== 1'b1 && w < 3000) begin
        @(posedge clk); #1;
        w++;
      end
      if (s_ready !== 1'b1) begin
        tests_run++;
        failed++;
        $display("FAIL beat_timeout: beat %0d s_ready=%b after %0d cycles, required 1", b, s_ready, w);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk); #1;
      accepted++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int w = 0;
    while ((sb.size() != 0 || img_valid !== 1'b0) && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    timed_out = (w >= 5000);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 64'd0; s_label = 4'd0;
    hold_cycles = 16'd1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (s_ready !== 1'b0) begin failed++; $display("FAIL rst_s_ready: got %b exp 0", s_ready); end
    tests_run++; if (image_data !== 794'd0) begin failed++; $display("FAIL rst_image: got nonzero exp 0"); end
    tests_run++; if (img_valid !== 1'b0) begin failed++; $display("FAIL rst_img_valid: got %b exp 0", img_valid); end
    tests_run++; if (frame_done !== 1'b0) begin failed++; $display("FAIL rst_frame_done: got %b exp 0", frame_done); end
    tests_run++; if (err !== 1'b0) begin failed++; $display("FAIL rst_err: got %b exp 0", err); end
    tests_run++; if (frame_cnt !== 16'd0) begin failed++; $display("FAIL rst_frame_cnt: got %0d exp 0", frame_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (s_ready !== 1'b1) begin failed++; $display("FAIL rst_release_ready: got %b exp 1", s_ready); end
  endtask

  task automatic test_all_ones();
    int acc, w;
    hold_cycles = 16'd3;
    fill_const(8'hFF);
    push_exp(4'd5, 3);
    send_frame(4'd5, 97, 98, acc);
    w = 0;
    while (frame_done !== 1'b1 && w < 500) begin @(posedge clk); #1; w++; end
    tests_run++; if (frame_done !== 1'b1) begin failed++; $display("FAIL ones_done_timeout: frame_done=%b exp 1", frame_done); end
    tests_run++; if (image_data[9:0] !== 10'h020) begin failed++; $display("FAIL ones_label: got %h exp 020", image_data[9:0]); end
    @(posedge clk); #1;
    tests_run++; if (img_valid !== 1'b0) begin failed++; $display("FAIL ones_valid_after: got %b exp 0", img_valid); end
    tests_run++; if (image_data !== 794'd0) begin failed++; $display("FAIL ones_image_after: got nonzero exp 0"); end
    tests_run++; if (frame_cnt !== 16'd1) begin failed++; $display("FAIL ones_frame_cnt: got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_alternating();
    int acc; bit to;
    hold_cycles = 16'd2;
    fill_alt();
    push_exp(4'd0, 2);
    send_frame(4'd0, 97, 98, acc);
    wait_idle(to);
    tests_run++; if (to) begin failed++; $display("FAIL alt_timeout: scoreboard %0d left exp 0", sb.size()); end
    tests_run++; if (frame_cnt !== 16'(exp_frames)) begin failed++; $display("FAIL alt_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_back_to_back();
    int acc, w; bit to;
    logic [15:0] c0;
    hold_cycles = 16'd200;
    fill_rand(); push_exp(4'd3, 200); send_frame(4'd3, 97, 98, acc);
    fill_rand(); push_exp(4'd7, 200); send_frame(4'd7, 97, 98, acc);
    tests_run++; if (s_ready !== 1'b0) begin failed++; $display("FAIL b2b_ready_drop: got %b exp 0", s_ready); end
    gap_cnt = 0;
    gap_en  = 1'b1;
    c0 = frame_cnt;
    w = 0;
    while (frame_cnt === c0 && w < 400) begin @(posedge clk); #1; w++; end
    tests_run++; if (s_ready !== 1'b1 || frame_cnt === c0) begin failed++; $display("FAIL b2b_ready_swap: s_ready=%b cnt=%0d exp ready 1 after swap", s_ready, frame_cnt); end
    fill_rand(); push_exp(4'd1, 200); send_frame(4'd1, 97, 98, acc);
    w = 0;
    while (frame_cnt !== 16'(exp_frames) && w < 400) begin @(posedge clk); #1; w++; end
    gap_en = 1'b0;
    tests_run++; if (gap_cnt != 0) begin failed++; $display("FAIL b2b_gap: got %0d invalid cycles exp 0", gap_cnt); end
    wait_idle(to);
    tests_run++; if (to || frame_cnt !== 16'(exp_frames)) begin failed++; $display("FAIL b2b_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_bad_last();
    int acc, e0; bit to;
    hold_cycles = 16'd4;
    e0 = err_cnt;
    fill_rand();
    send_frame(4'd2, 50, 51, acc);
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL badlast_err: got %0d pulses exp 1", err_cnt - e0); end
    tests_run++; if (img_valid !== 1'b0) begin failed++; $display("FAIL badlast_valid: got %b exp 0", img_valid); end
    fill_rand(); push_exp(4'd9, 4); send_frame(4'd9, 97, 98, acc);
    wait_idle(to);
    tests_run++; if (to || frame_cnt !== 16'(exp_frames)) begin failed++; $display("FAIL badlast_recover: got %0d exp %0d", frame_cnt, exp_frames); end
  endtask

  task automatic test_bad_label();
    int acc, e0;
    e0 = err_cnt;
    fill_rand();
    send_frame(4'd12, 97, 98, acc);
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (acc != 98) begin failed++; $display("FAIL badlabel_beats: got %0d exp 98", acc); end
    tests_run++; if (err_cnt - e0 != 1) begin failed++; $display("FAIL badlabel_err: got %0d pulses exp 1", err_cnt - e0); end
    tests_run++; if (frame_cnt !== 16'(exp_frames) || img_valid !== 1'b0) begin failed++; $display("FAIL badlabel_cnt: got %0d valid %b exp %0d valid 0", frame_cnt, img_valid, exp_frames); end
  endtask

  task automatic test_reset_mid();
    int acc, w; bit to;
    hold_cycles = 16'd50;
    fill_rand();
    send_frame(4'd4, -1, 40, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (s_ready !== 1'b0 || img_valid !== 1'b0 || err !== 1'b0 || frame_cnt !== 16'd0) begin
      failed++; $display("FAIL midrst_fill: ready=%b valid=%b err=%b cnt=%0d exp 0 0 0 0", s_ready, img_valid, err, frame_cnt);
    end
    rst = 1'b0; exp_frames = 0;
    fill_rand(); push_exp(4'd6, 50); send_frame(4'd6, 97, 98, acc);
    w = 0;
    while (img_valid !== 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (img_valid !== 1'b0 || image_data !== 794'd0 || frame_done !== 1'b0 || frame_cnt !== 16'd0 || s_ready !== 1'b0) begin
      failed++; $display("FAIL midrst_show: valid=%b done=%b cnt=%0d ready=%b exp all 0", img_valid, frame_done, frame_cnt, s_ready);
    end
    rst = 1'b0; exp_frames = 0;
    hold_cycles = 16'd3;
    fill_rand(); push_exp(4'd8, 3); send_frame(4'd8, 97, 98, acc);
    wait_idle(to);
    tests_run++; if (to || frame_cnt !== 16'd1) begin failed++; $display("FAIL midrst_fresh: got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_hold_zero();
    int acc, d0; bit to;
    hold_cycles = 16'd0;
    d0 = done_cnt;
    fill_rand(); push_exp(4'd1, 0); send_frame(4'd1, 97, 98, acc);
    fill_rand(); push_exp(4'd2, 0); send_frame(4'd2, 97, 98, acc);
    wait_idle(to);
    tests_run++; if (to || frame_cnt !== 16'(exp_frames)) begin failed++; $display("FAIL hold0_cnt: got %0d exp %0d", frame_cnt, exp_frames); end
    tests_run++; if (done_cnt - d0 != 2) begin failed++; $display("FAIL hold0_done: got %0d pulses exp 2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_back_to_back();
    test_bad_last();
    test_bad_label();
    test_reset_mid();
    test_hold_zero();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
